// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: round-robin two-port arbiter and access sequencer for a single-port data memory.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 wins ties).
module mem_arbiter_2p #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic sel, any_req, in_range, lat_port, lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  assign any_req  = p0_req | p1_req;
  assign in_range = lat_addr < ADDR_W'(MEM_DEPTH);
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign sel = ~p0_req;
`else
  logic last;
  assign sel = (p0_req & p1_req) ? ~last : p1_req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (state == IDLE && any_req) last <= sel;
`endif
  always_comb begin
    state_nx  = (state == IDLE) ? (any_req ? ACCESS : IDLE) : (state == ACCESS) ? DONE : IDLE;
    p0_gnt    = (state == IDLE) && p0_req && !sel;
    p1_gnt    = (state == IDLE) && p1_req && sel;
    p0_done   = (state == DONE) && !lat_port;
    p1_done   = (state == DONE) && lat_port;
    p0_err    = p0_done && !in_range;
    p1_err    = p1_done && !in_range;
    mem_we    = (state == ACCESS) && lat_we && in_range;
    mem_addr  = (state == ACCESS) ? lat_addr : '0;
    mem_wdata = (state == ACCESS) ? lat_wdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        lat_port  <= sel;
        lat_we    <= sel ? p1_we : p0_we;
        lat_addr  <= sel ? p1_addr : p0_addr;
        lat_wdata <= sel ? p1_wdata : p0_wdata;
      end
      // out-of-range reads capture zero rather than whatever the memory decodes
      if (state == ACCESS && !lat_we && !lat_port) p0_rdata <= in_range ? mem_rdata : '0;
      if (state == ACCESS && !lat_we && lat_port) p1_rdata <= in_range ? mem_rdata : '0;
    end
endmodule
